// File: rtl/cc_deserializer_pkg.sv
// Shared widths, FIFO entry layout and FSM state type for the cache-line
// deserializer (R channel -> line FIFO) and its FIFO-read-side serializer.
package cc_deserializer_pkg;

    localparam int BEATS_PER_LINE = 8;
    localparam int DATA_W         = 64;
    localparam int LINE_W         = 512;
    localparam int OFFSET_W       = 6;
    localparam int CNT_W          = $clog2(BEATS_PER_LINE);
    localparam int ENTRY_W        = OFFSET_W + LINE_W;

    typedef struct packed {
        logic [OFFSET_W-1:0] offset;
        logic [LINE_W-1:0]   line;
    } line_entry_t;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_PUSH    = 1'b1
    } deser_state_e;

endpackage

// File: rtl/cc_deserializer.sv
// Collects eight 64-bit critical-word-first beats into one 512-bit line and
// pushes {offset, line} into a FIFO. Define CC_DESER_RLAST_CHECK_EN for rlast checking.
module cc_deserializer
    import cc_deserializer_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic                rlast_i,
    input  logic                rvalid_i,
    output logic                rready_o,
    input  logic [OFFSET_W-1:0] offset_i,
    input  logic                fifo_full_i,
    output logic                fifo_wren_o,
    output logic [ENTRY_W-1:0]  fifo_wdata_o,
    output logic                error_o
);

    deser_state_e        state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OFFSET_W-1:0] off_q, off_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                hs;
    logic [CNT_W-1:0]    base_word;
    logic [CNT_W-1:0]    slot;
    line_entry_t         entry;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        line_d      = line_q;
        fifo_wren_o = 1'b0;
        rready_o    = (state_q == ST_COLLECT);
        hs          = rvalid_i & rready_o;
        // Beat 0 addresses from the live offset since off_q is not loaded yet.
        base_word   = (cnt_q == '0) ? offset_i[OFFSET_W-1 -: CNT_W]
                                    : off_q[OFFSET_W-1 -: CNT_W];
        slot        = base_word + cnt_q;

        case (state_q)
            ST_COLLECT: begin
                if (hs) begin
                    if (cnt_q == '0) begin
                        off_d = offset_i;
                    end
                    for (int s = 0; s < BEATS_PER_LINE; s++) begin
                        if (slot == CNT_W'(s)) begin
                            line_d[(BEATS_PER_LINE-1-s)*DATA_W +: DATA_W] = rdata_i;
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(BEATS_PER_LINE-1)) begin
                        state_d = ST_PUSH;
                    end
                end
            end
            ST_PUSH: begin
                fifo_wren_o = !fifo_full_i;
                if (!fifo_full_i) begin
                    state_d = ST_COLLECT;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_COLLECT;
            cnt_q   <= '0;
            off_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            line_q  <= line_d;
        end
    end

    assign entry        = '{offset: off_q, line: line_q};
    assign fifo_wdata_o = entry;

`ifdef CC_DESER_RLAST_CHECK_EN
    logic err_q, err_d;

    assign err_d = err_q | (hs & (rlast_i != (cnt_q == CNT_W'(BEATS_PER_LINE-1))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign error_o = err_q;
`else
    logic unused_rlast;

    assign unused_rlast = rlast_i;
    assign error_o      = 1'b0;
`endif

endmodule
